pipe_flow_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (F/D/E/M/W).
- Drives the enables and flush lines of the PC, DReg, EReg, MReg and WReg, including WRegFlush, and drives the PC source select.
- Tracks multiply/divide unit occupancy with an internal busy counter.
- Sequences exception/interrupt entry (two-cycle flush-then-redirect) and ERET return.

---
 rtl/pipe_flow_ctrl_if.sv | 32 +++
 rtl/pipe_flow_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_flow_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipe_flow_ctrl_if.sv
// Handshake bundle between the hazard/exception detectors and the pipeline
// flow controller: hazard requests one way, register enables/flushes the other.
interface pipe_flow_ctrl_if;
   logic       StallReqD;
   logic       MDStartE;
   logic       MDIsDivE;
   logic       MDUseD;
   logic       ExcM;
   logic       EretM;
   logic       PCEn;
   logic       DRegEn;
   logic       DRegFlush;
   logic       ERegFlush;
   logic       MRegFlush;
   logic       WRegFlush;
   logic [1:0] PCSel;
   logic       MDBusy;
   logic       InExc;

   // master: the pipeline side that raises requests and obeys the controls
   modport master (
      output StallReqD, MDStartE, MDIsDivE, MDUseD, ExcM, EretM,
      input  PCEn, DRegEn, DRegFlush, ERegFlush, MRegFlush, WRegFlush,
             PCSel, MDBusy, InExc
   );

   modport slave (
      input  StallReqD, MDStartE, MDIsDivE, MDUseD, ExcM, EretM,
      output PCEn, DRegEn, DRegFlush, ERegFlush, MRegFlush, WRegFlush,
             PCSel, MDBusy, InExc
   );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard stalls, mult/div
// occupancy tracking, two-cycle exception entry and ERET redirect.
module pipe_flow_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input logic              Clk,
   input logic              Reset,
   pipe_flow_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      RUN       = 2'd0,
      EXC_FLUSH = 2'd1,
      EXC_REDIR = 2'd2
   } state_t;

   localparam logic [1:0] PCSEL_SEQ     = 2'd0;
   localparam logic [1:0] PCSEL_HANDLER = 2'd1;
   localparam logic [1:0] PCSEL_EPC     = 2'd2;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             md_busy;
   logic             stall;
   logic             md_load;

   assign md_busy = (cnt_reg != '0);
   assign stall   = bus.StallReqD | (bus.MDUseD & (md_busy | bus.MDStartE));
   // A mult/div in E that is being flushed away must not occupy the unit.
   assign md_load = bus.MDStartE & (state_reg == RUN) & ~bus.ExcM & ~bus.EretM;

   always_comb begin
      cnt_next = cnt_reg;
      if (md_load)
         cnt_next = bus.MDIsDivE ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      else if (md_busy)
         cnt_next = cnt_reg - 1'b1;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:       if (bus.ExcM) state_next = EXC_FLUSH;
         EXC_FLUSH: state_next = EXC_REDIR;
         EXC_REDIR: state_next = RUN;
         default:   state_next = RUN;
      endcase
   end

   always_comb begin
      bus.PCEn      = 1'b1;
      bus.DRegEn    = 1'b1;
      bus.DRegFlush = 1'b0;
      bus.ERegFlush = 1'b0;
      bus.MRegFlush = 1'b0;
      bus.WRegFlush = 1'b0;
      bus.PCSel     = PCSEL_SEQ;
      bus.InExc     = 1'b0;
      case (state_reg)
         RUN: begin
            if (bus.ExcM) begin
               bus.PCEn      = 1'b0;
               bus.DRegFlush = 1'b1;
               bus.ERegFlush = 1'b1;
               bus.MRegFlush = 1'b1;
               bus.WRegFlush = 1'b1;
            end else if (bus.EretM) begin
               bus.PCSel     = PCSEL_EPC;
               bus.DRegFlush = 1'b1;
               bus.ERegFlush = 1'b1;
            end else if (stall) begin
               bus.PCEn      = 1'b0;
               bus.DRegEn    = 1'b0;
               bus.ERegFlush = 1'b1;
            end
         end
         // CP0 captures EPC/Cause while the younger stages are held empty.
         EXC_FLUSH: begin
            bus.PCEn      = 1'b0;
            bus.DRegFlush = 1'b1;
            bus.ERegFlush = 1'b1;
            bus.MRegFlush = 1'b1;
         end
         EXC_REDIR: begin
            bus.PCSel     = PCSEL_HANDLER;
            bus.DRegFlush = 1'b1;
            bus.ERegFlush = 1'b1;
            bus.InExc     = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.MDBusy = md_busy;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg <= RUN;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Scoreboard bench for pipe_flow_ctrl: the driver queues hand-computed output
// vectors per cycle, the monitor pops and compares them mid-cycle.
module tb_pipe_flow_ctrl;
   logic Clk;
   logic Reset;

   pipe_flow_ctrl_if bus_if ();

   pipe_flow_ctrl #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10),
      .CNT_W       (4)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus_if.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [9:0] exp_q[$];
   string      name_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;

   // {PCEn, DRegEn, DRegFlush, ERegFlush, MRegFlush, WRegFlush, PCSel, MDBusy, InExc}
   function automatic logic [9:0] v(input bit pcen, input bit dregen, input bit df,
                                    input bit ef, input bit mf, input bit wf,
                                    input int pcsel, input bit busy, input bit inexc);
      logic [1:0] sel;
      sel = pcsel[1:0];
      return {pcen, dregen, df, ef, mf, wf, sel, busy, inexc};
   endfunction

   task automatic step(input bit rst, input bit stl, input bit mds, input bit isdiv,
                       input bit mdu, input bit exc, input bit eret,
                       input logic [9:0] expv, input string nm);
      @(posedge Clk);
      #1;
      Reset            = rst;
      bus_if.StallReqD = stl;
      bus_if.MDStartE  = mds;
      bus_if.MDIsDivE  = isdiv;
      bus_if.MDUseD    = mdu;
      bus_if.ExcM      = exc;
      bus_if.EretM     = eret;
      exp_q.push_back(expv);
      name_q.push_back(nm);
   endtask

   // Monitor: outputs are valid every cycle, sampled on the falling edge.
   always @(negedge Clk) begin
      if (exp_q.size() > 0) begin
         logic [9:0] got;
         logic [9:0] expv;
         string      nm;
         expv = exp_q.pop_front();
         nm   = name_q.pop_front();
         got  = {bus_if.PCEn, bus_if.DRegEn, bus_if.DRegFlush, bus_if.ERegFlush,
                 bus_if.MRegFlush, bus_if.WRegFlush, bus_if.PCSel, bus_if.MDBusy,
                 bus_if.InExc};
         n_tests++;
         if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, expv);
         end else begin
            $display("ok   %s: %b", nm, got);
         end
      end
   end

   logic [9:0] r_idle, r_stall, r_exc0, r_exc1, r_redir, r_busy, r_stall_busy;

   initial begin
      Reset            = 1'b1;
      bus_if.StallReqD = 1'b0;
      bus_if.MDStartE  = 1'b0;
      bus_if.MDIsDivE  = 1'b0;
      bus_if.MDUseD    = 1'b0;
      bus_if.ExcM      = 1'b0;
      bus_if.EretM     = 1'b0;

      r_idle       = v(1, 1, 0, 0, 0, 0, 0, 0, 0);
      r_stall      = v(0, 0, 0, 1, 0, 0, 0, 0, 0);
      r_stall_busy = v(0, 0, 0, 1, 0, 0, 0, 1, 0);
      r_busy       = v(1, 1, 0, 0, 0, 0, 0, 1, 0);
      r_exc0       = v(0, 1, 1, 1, 1, 1, 0, 0, 0);
      r_exc1       = v(0, 1, 1, 1, 1, 0, 0, 0, 0);
      r_redir      = v(1, 1, 1, 1, 0, 0, 1, 0, 1);

      //   rst stl mds div use exc eret
      step(1, 0, 0, 0, 0, 0, 0, r_idle, "reset");
      step(0, 0, 0, 0, 0, 0, 0, r_idle, "idle");

      // load-use stall for one cycle
      step(0, 1, 0, 0, 0, 0, 0, r_stall, "lu_stall");
      step(0, 0, 0, 0, 0, 0, 0, r_idle, "lu_release");

      // mult then dependent mflo held: start cycle + 5 busy cycles stalled
      step(0, 0, 1, 0, 1, 0, 0, r_stall, "mul_start");
      for (int i = 0; i < 5; i++)
         step(0, 0, 0, 0, 1, 0, 0, r_stall_busy, $sformatf("mul_busy%0d", i));
      step(0, 0, 0, 0, 1, 0, 0, r_idle, "mul_release");

      // exception entry sequence
      step(0, 0, 0, 0, 0, 1, 0, r_exc0, "exc_c0");
      step(0, 0, 0, 0, 0, 0, 0, r_exc1, "exc_c1");
      step(0, 0, 0, 0, 0, 0, 0, r_redir, "exc_c2");
      step(0, 0, 0, 0, 0, 0, 0, r_idle, "exc_c3");

      // ExcM beats EretM and kills the div start; fresh ExcM in EXC_REDIR ignored
      step(0, 0, 1, 1, 0, 1, 1, r_exc0, "prio_exc");
      step(0, 0, 0, 0, 0, 0, 0, r_exc1, "prio_flush");
      step(0, 1, 0, 0, 1, 1, 0, r_redir, "redir_ignore");
      step(0, 0, 0, 0, 0, 0, 0, r_idle, "redir_to_run");

      // ERET while a divide is in flight (counter 10 -> 6, then ERET)
      step(0, 0, 1, 1, 0, 0, 0, r_idle, "div_start");
      for (int i = 0; i < 4; i++)
         step(0, 0, 0, 0, 0, 0, 0, r_busy, $sformatf("div_busy%0d", 10 - i));
      step(0, 0, 0, 0, 0, 0, 1, v(1, 1, 1, 1, 0, 0, 2, 1, 0), "eret_div6");
      for (int i = 0; i < 5; i++)
         step(0, 0, 0, 0, 0, 0, 0, r_busy, $sformatf("div_busy%0d", 5 - i));
      step(0, 0, 0, 0, 0, 0, 0, r_idle, "div_done");

      // reset asserted mid-cycle while in EXC_FLUSH with counter 7
      step(0, 0, 1, 1, 0, 0, 0, r_idle, "div2_start");
      step(0, 0, 0, 0, 0, 0, 0, r_busy, "div2_busy10");
      step(0, 0, 0, 0, 0, 0, 0, r_busy, "div2_busy9");
      step(0, 0, 0, 0, 0, 1, 0, v(0, 1, 1, 1, 1, 1, 0, 1, 0), "div2_exc8");
      step(1, 0, 0, 0, 0, 0, 0, r_idle, "async_reset");
      step(0, 0, 0, 0, 0, 0, 0, r_idle, "post_reset");

      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(posedge Clk);
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
